tff_toggle_arbiter: RTL

Round-robin arbiter and sequencer for a shared bank of T flip-flops. Up to NREQ requesters each ask to toggle one bit of a WIDTH-bit register. The block grants one requester at a time, with a bounded burst per grant. It drives the per-bit toggle enables into the bank and owns the bank state. It sits between toggle-producing logic and the T flip-flop register.

---
 rtl/tff_toggle_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/tff_toggle_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tff_toggle_arbiter
// Brief   : Round-robin burst arbiter owning a bank of T flip-flops; optional
//           per-bit lock mask enabled by defining TFF_ARB_LOCK_EN.
// Revision: 1.0
// ============================================================================
module tff_toggle_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int BURST = 3,
    parameter int SELW  = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SELW-1:0] sel,
`ifdef TFF_ARB_LOCK_EN
    input  logic [WIDTH-1:0]     lock,
`endif
    output logic [NREQ-1:0]      gnt,
    output logic [WIDTH-1:0]     t_vec,
    output logic [WIDTH-1:0]     q,
    output logic                 busy
);

    localparam int C_PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [C_PTRW-1:0]   ptr_q, ptr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [WIDTH-1:0]    bank_q, bank_d;

    logic [C_PTRW-1:0]   w_gidx;
    logic [C_PTRW-1:0]   w_nxt_ptr;
    logic [C_PTRW-1:0]   w_start;
    logic [SELW-1:0]     w_gsel;
    logic                w_greq;
    logic [NREQ-1:0]     w_win_hi;
    logic [NREQ-1:0]     w_win_any;
    logic [NREQ-1:0]     w_win_oh;
    logic [WIDTH-1:0]    w_toggle;
    logic                w_release;

    // Decode the one-hot grant into an index and pick up that requester's select.
    always_comb begin
        w_gidx = '0;
        w_gsel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                w_gidx = C_PTRW'(i);
                w_gsel = sel[i*SELW +: SELW];
            end
        end
        w_greq    = |(req & gnt_q);
        w_nxt_ptr = (w_gidx == C_PTRW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
        w_start   = (state_q == ST_SERVE) ? w_nxt_ptr : ptr_q;
    end

    // Rotating priority: lowest requester at or above the start index wins,
    // otherwise wrap to the lowest requester overall.
    always_comb begin
        w_win_hi  = '0;
        w_win_any = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win_any    = '0;
                w_win_any[i] = 1'b1;
                if (i >= int'(w_start)) begin
                    w_win_hi    = '0;
                    w_win_hi[i] = 1'b1;
                end
            end
        end
        w_win_oh = (|w_win_hi) ? w_win_hi : w_win_any;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        w_toggle  = '0;
        w_release = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d   = w_win_oh;
                    cnt_d   = '0;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (w_greq) begin
                    if (int'(w_gsel) < WIDTH) begin
                        w_toggle = WIDTH'(1) << w_gsel;
                    end
`ifdef TFF_ARB_LOCK_EN
                    w_toggle = w_toggle & ~lock;
`endif
                    cnt_d     = cnt_q + 4'd1;
                    w_release = ((cnt_q + 4'd1) == 4'(BURST));
                end else begin
                    w_release = 1'b1;
                end

                if (w_release) begin
                    ptr_d = w_nxt_ptr;
                    cnt_d = '0;
                    if (|req) begin
                        gnt_d = w_win_oh;
                    end else begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase

        bank_d = bank_q ^ w_toggle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            bank_q  <= bank_d;
        end
    end

    assign gnt   = gnt_q;
    assign t_vec = w_toggle;
    assign q     = bank_q;
    assign busy  = (state_q == ST_SERVE);

endmodule
`default_nettype wire
